shift_add_datapath: RTL and testbench

- Datapath stage directly downstream of controller2B.
- Consumes the controller's w/b/s operands and its load_w/cnt strobes.
- Computes result = W*B + S using a radix-2 shift-add multiplier, one partial product per cnt strobe, with a final bias cycle.
- Presents a held result with a done flag for the next stage and a busy flag back toward the controller.

---
 rtl/shift_add_datapath.sv | 128 ++++++++++++
 tb/tb_shift_add_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_datapath.sv
// Radix-2 shift-add multiply-accumulate stage: result = W*B + S, one partial
// product per cnt strobe, followed by a single bias cycle and a held result.
module shift_add_datapath #(
    parameter int WIDTH  = 6,
    parameter int STEP_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     w_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [WIDTH-1:0]     s_in,
    input  logic                 load_w_in,
    input  logic                 cnt_in,
    output logic [2*WIDTH-1:0]   result_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [STEP_W-1:0]    step_out,
    output logic [1:0]           state_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_BIAS = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    logic [1:0]           state_r, state_nxt_s;
    logic [2*WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [WIDTH-1:0]     w_r, w_nxt_s;
    logic [WIDTH-1:0]     b_r, b_nxt_s;
    logic [WIDTH-1:0]     s_r, s_nxt_s;
    logic [STEP_W-1:0]    step_r, step_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;
    logic [2*WIDTH-1:0]   pp_s;
    logic [2*WIDTH-1:0]   bias_s;

    // Partial product and bias operand, both zero-extended to accumulator width
    always_comb begin
        pp_s   = {{WIDTH{1'b0}}, w_r} << step_r;
        bias_s = {{WIDTH{1'b0}}, s_r};
    end

    // Next-state and datapath update; load beats cnt in IDLE/DONE
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        w_nxt_s     = w_r;
        b_nxt_s     = b_r;
        s_nxt_s     = s_r;
        step_nxt_s  = step_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (load_w_in) begin
                    w_nxt_s     = w_in;
                    b_nxt_s     = b_in;
                    s_nxt_s     = s_in;
                    acc_nxt_s   = {(2*WIDTH){1'b0}};
                    step_nxt_s  = {STEP_W{1'b0}};
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (cnt_in) begin
                    if (b_r[0]) begin
                        acc_nxt_s = acc_r + pp_s;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                    b_nxt_s    = b_r >> 1;
                    step_nxt_s = step_r + STEP_ONE;
                    if (step_r == LAST_STEP) begin
                        state_nxt_s = ST_BIAS;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BIAS: begin
                acc_nxt_s   = acc_r + bias_s;
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                acc_nxt_s   = {(2*WIDTH){1'b0}};
                step_nxt_s  = {STEP_W{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_BIAS);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, operand and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= {(2*WIDTH){1'b0}};
            w_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            step_r  <= {STEP_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            w_r     <= w_nxt_s;
            b_r     <= b_nxt_s;
            s_r     <= s_nxt_s;
            step_r  <= step_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign result_out = acc_r;
    assign step_out   = step_r;
    assign state_out  = state_r;
    assign busy_out   = busy_r;
    assign done_out   = done_r;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath: expected results are queued at load
// time and checked by a monitor on each rising done_out.
module tb_shift_add_datapath;

    logic        clk;
    logic        reset;
    logic [5:0]  w_in, b_in, s_in;
    logic        load_w_in, cnt_in;
    logic [11:0] result_out;
    logic        busy_out, done_out;
    logic [2:0]  step_out;
    logic [1:0]  state_out;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic done_prev = 1'b0;

    shift_add_datapath #(.WIDTH(6), .STEP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_in       (w_in),
        .b_in       (b_in),
        .s_in       (s_in),
        .load_w_in  (load_w_in),
        .cnt_in     (cnt_in),
        .result_out (result_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .step_out   (step_out),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Packs all outputs so a single compare covers the whole port set
    function automatic int all_outs();
        return {result_out, busy_out, done_out, step_out, state_out};
    endfunction

    // Issues one operation, optionally stalling or injecting an ignored load
    task automatic run_op(input logic [5:0] w, input logic [5:0] b, input logic [5:0] s,
                          input int exp_res, input int stall_at, input int stall_len,
                          input int ign_at, output int edges);
        bit stalled = 0;
        bit injected = 0;
        bit saw_idle = 0;
        int fz_acc, fz_step;
        @(negedge clk);
        w_in = w; b_in = b; s_in = s;
        load_w_in = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk); #1;
        load_w_in = 1'b0;
        edges = 1;
        check("after_load_state", int'(state_out), 1);
        check("after_load_step_acc", int'({result_out, step_out}), 0);
        check("after_load_busy_done", int'({busy_out, done_out}), 2);
        while (!done_out && edges < 60) begin
            if (state_out == 2'd0) saw_idle = 1;
            if (stall_len > 0 && !stalled && int'(step_out) == stall_at && state_out == 2'd1) begin
                stalled = 1;
                cnt_in = 1'b0;
                fz_acc = int'(result_out);
                fz_step = int'(step_out);
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    edges++;
                end
                check("stall_acc_frozen", int'(result_out), fz_acc);
                check("stall_step_frozen", int'(step_out), fz_step);
                cnt_in = 1'b1;
            end else if (ign_at >= 0 && !injected && int'(step_out) == ign_at && state_out == 2'd1) begin
                injected = 1;
                w_in = 6'd1; b_in = 6'd1; s_in = 6'd0;
                load_w_in = 1'b1;
                @(posedge clk); #1;
                load_w_in = 1'b0;
                edges++;
                check("ignored_load_step", int'(step_out), ign_at + 1);
            end else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        check("no_idle_between", int'(saw_idle), 0);
        check("done_reached", int'(done_out), 1);
    endtask

    initial begin
        int edges;
        int n;
        reset = 1'b0; load_w_in = 1'b0; cnt_in = 1'b0;
        w_in = 6'd0; b_in = 6'd0; s_in = 6'd0;
        fork
            // Monitor: pop and compare on each rising done_out
            forever begin
                @(negedge clk);
                if (done_out && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got result %0d with no expected entry", result_out);
                    end else begin
                        check("sb_result", int'(result_out), exp_q.pop_front());
                        check("sb_step", int'(step_out), 6);
                        check("sb_busy", int'(busy_out), 0);
                    end
                end
                done_prev = done_out;
            end
            begin
                #3;
                check("reset_outputs", all_outs(), 0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                cnt_in = 1'b1;
                repeat (3) @(negedge clk);
                check("idle_ignores_cnt", all_outs(), 0);

                run_op(6'd5, 6'd3, 6'd0, 15, -1, 0, -1, edges);
                check("latency_basic", edges, 8);

                run_op(6'd63, 6'd63, 6'd63, 4032, -1, 0, -1, edges);
                check("latency_max", edges, 8);

                run_op(6'd10, 6'd6, 6'd7, 67, 2, 3, -1, edges);
                check("latency_stall", edges, 11);

                run_op(6'd9, 6'd0, 6'd4, 4, -1, 0, -1, edges);
                check("latency_b0", edges, 8);
                run_op(6'd2, 6'd2, 6'd1, 5, -1, 0, -1, edges);
                check("done_low_b2b", edges, 8);

                run_op(6'd12, 6'd11, 6'd3, 135, -1, 0, 3, edges);
                check("latency_ignored_load", edges, 8);

                // Abort mid-operation with an asynchronous reset
                @(negedge clk);
                w_in = 6'd7; b_in = 6'd5; s_in = 6'd2;
                load_w_in = 1'b1;
                @(posedge clk); #1;
                load_w_in = 1'b0;
                n = 0;
                while (step_out != 3'd4 && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("abort_reached_step4", int'(step_out), 4);
                #2;
                reset = 1'b0;
                #1;
                check("async_reset_outputs", all_outs(), 0);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("post_reset_idle", all_outs(), 0);

                run_op(6'd7, 6'd5, 6'd2, 37, -1, 0, -1, edges);
                check("latency_after_reset", edges, 8);

                repeat (3) @(negedge clk);
                check("scoreboard_drained", exp_q.size(), 0);
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
